// File: rtl/evr_marker_pkg.sv
//------------------------------------------------------------------------------
// evr_marker_pkg : shared types and window helper for the EVR marker monitor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package evr_marker_pkg;

  localparam int c_ERR_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    SEARCH   = 2'd1,
    MEASURE  = 2'd2
  } chState_e;

  typedef struct packed {
    logic [32:0] lo;
    logic [32:0] hi;
  } window_t;

  // Widest supported COUNT_WIDTH is 32; hi clamps to the counter's all-ones.
  function automatic window_t evrWindow(input logic [31:0] nom,
                                        input int tolShift,
                                        input int countWidth);
    logic [32:0] tol;
    logic [32:0] allOnes;
    window_t     win;
    tol     = {1'b0, nom} >> tolShift;
    allOnes = (33'd1 << countWidth) - 33'd1;
    win.lo  = {1'b0, nom} - tol;
    win.hi  = {1'b0, nom} + tol;
    if (win.hi > allOnes) win.hi = allOnes;
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/evr_marker_channel.sv
//------------------------------------------------------------------------------
// evr_marker_channel : one marker channel - synchroniser, period check, errors
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module evr_marker_channel
  import evr_marker_pkg::*;
#(
  parameter int    COUNT_WIDTH   = 28,
  parameter int    TOL_SHIFT     = 3,
  parameter int    GOOD_REQUIRED = 2,
  parameter int    ERR_WIDTH     = c_ERR_WIDTH_DEFAULT,
  parameter string DEBUG         = "false"
) (
  input  logic                   sysClk,
  input  logic                   sysRst_n,
  input  logic                   evrMarker,
  input  logic [COUNT_WIDTH-1:0] nominalPeriod,
  input  logic                   clearErrors,
  output logic                   isValid,
  output logic                   markerStrobe,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [ERR_WIDTH-1:0]   errorCount
);

  localparam logic [3:0] c_GOOD = 4'(GOOD_REQUIRED);

  logic                   r_sync0, r_sync1, r_delay, r_edge, r_strobe, r_valid;
  logic [COUNT_WIDTH-1:0] r_count, r_period;
  logic [3:0]             r_good;
  logic [ERR_WIDTH-1:0]   r_err;
  chState_e               r_state;

  chState_e               w_nextState;
  logic [COUNT_WIDTH-1:0] w_nextCount, w_nextPeriod;
  logic [3:0]             w_nextGood, w_goodInc;
  logic                   w_nextValid, w_incErr;
  logic [ERR_WIDTH-1:0]   w_nextErr;
  logic [COUNT_WIDTH:0]   w_spacing;
  logic [32:0]            w_spacing33;
  logic                   w_inWindow;
  window_t                w_win;

  assign w_win       = evrWindow(32'(nominalPeriod), TOL_SHIFT, COUNT_WIDTH);
  assign w_spacing   = {1'b0, r_count} + (COUNT_WIDTH+1)'(1);
  assign w_spacing33 = 33'(w_spacing);
  assign w_inWindow  = (w_spacing33 >= w_win.lo) && (w_spacing33 <= w_win.hi);
  assign w_goodInc   = (r_good == c_GOOD) ? r_good : r_good + 4'd1;

  always_comb begin
    w_nextState  = r_state;
    w_nextCount  = r_count;
    w_nextGood   = r_good;
    w_nextValid  = r_valid;
    w_nextPeriod = r_period;
    w_incErr     = 1'b0;
    if (nominalPeriod == '0) begin
      w_nextState = DISABLED;
      w_nextCount = '0;
      w_nextGood  = '0;
      w_nextValid = 1'b0;
    end else begin
      case (r_state)
        DISABLED: w_nextState = SEARCH;
        SEARCH: begin
          w_nextGood  = '0;
          w_nextValid = 1'b0;
          if (r_edge) begin
            w_nextCount = '0;
            w_nextState = MEASURE;
          end
        end
        MEASURE: begin
          // An edge landing on the timeout cycle is judged as a late edge.
          if (r_edge) begin
            w_nextCount  = '0;
            w_nextPeriod = w_spacing[COUNT_WIDTH-1:0];
            if (w_inWindow) begin
              w_nextGood  = w_goodInc;
              w_nextValid = (w_goodInc == c_GOOD);
            end else begin
              w_nextGood  = '0;
              w_nextValid = 1'b0;
              w_incErr    = 1'b1;
            end
          end else if (w_spacing33 > w_win.hi) begin
            w_nextState = SEARCH;
            w_nextCount = '0;
            w_nextGood  = '0;
            w_nextValid = 1'b0;
            w_incErr    = 1'b1;
          end else begin
            w_nextCount = r_count + COUNT_WIDTH'(1);
          end
        end
        default: w_nextState = SEARCH;
      endcase
    end
    w_nextErr = r_err;
    if (clearErrors)
      w_nextErr = '0;
    else if (w_incErr && (r_err != '1))
      w_nextErr = r_err + ERR_WIDTH'(1);
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_delay  <= 1'b0;
      r_edge   <= 1'b0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_period <= '0;
      r_good   <= '0;
      r_err    <= '0;
      r_state  <= SEARCH;
    end else begin
      r_sync0  <= evrMarker;
      r_sync1  <= r_sync0;
      r_delay  <= r_sync1;
      r_edge   <= r_sync1 & ~r_delay;
      r_strobe <= r_edge;
      r_valid  <= w_nextValid;
      r_count  <= w_nextCount;
      r_period <= w_nextPeriod;
      r_good   <= w_nextGood;
      r_err    <= w_nextErr;
      r_state  <= w_nextState;
    end
  end

  generate
    if (DEBUG == "true") begin : g_debug
      (* mark_debug = "true" *) logic [1:0] w_dbgState;
      assign w_dbgState = r_state;
    end
  endgenerate

  assign isValid      = r_valid;
  assign markerStrobe = r_strobe;
  assign period       = r_period;
  assign errorCount   = r_err;

endmodule

`default_nettype wire

// File: rtl/evr_marker_monitor.sv
//------------------------------------------------------------------------------
// evr_marker_monitor : CHANNELS independent EVR marker period monitors
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module evr_marker_monitor
  import evr_marker_pkg::*;
#(
  parameter int    CHANNELS      = 2,
  parameter int    COUNT_WIDTH   = 28,
  parameter int    TOL_SHIFT     = 3,
  parameter int    GOOD_REQUIRED = 2,
  parameter int    ERR_WIDTH     = c_ERR_WIDTH_DEFAULT,
  parameter string DEBUG         = "false"
) (
  input  logic                            sysClk,
  input  logic                            sysRst_n,
  input  logic [CHANNELS-1:0]             evrMarker,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] nominalPeriod,
  input  logic [CHANNELS-1:0]             clearErrors,
  output logic [CHANNELS-1:0]             isValid,
  output logic [CHANNELS-1:0]             markerStrobe,
  output logic [CHANNELS*COUNT_WIDTH-1:0] period,
  output logic [CHANNELS*ERR_WIDTH-1:0]   errorCount
);

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
      evr_marker_channel #(
        .COUNT_WIDTH  (COUNT_WIDTH),
        .TOL_SHIFT    (TOL_SHIFT),
        .GOOD_REQUIRED(GOOD_REQUIRED),
        .ERR_WIDTH    (ERR_WIDTH),
        .DEBUG        (DEBUG)
      ) u_channel (
        .sysClk       (sysClk),
        .sysRst_n     (sysRst_n),
        .evrMarker    (evrMarker[ch]),
        .nominalPeriod(nominalPeriod[ch*COUNT_WIDTH +: COUNT_WIDTH]),
        .clearErrors  (clearErrors[ch]),
        .isValid      (isValid[ch]),
        .markerStrobe (markerStrobe[ch]),
        .period       (period[ch*COUNT_WIDTH +: COUNT_WIDTH]),
        .errorCount   (errorCount[ch*ERR_WIDTH +: ERR_WIDTH])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_evr_marker_monitor.sv
//------------------------------------------------------------------------------
// tb_evr_marker_monitor : scoreboard bench for evr_marker_monitor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_evr_marker_monitor;

  localparam int CW = 28;
  localparam int EW = 16;

  logic              sysClk = 1'b0;
  logic              sysRst_n;
  logic              m0 = 1'b0, m1 = 1'b0, m2 = 1'b0;
  logic [1:0]        evrMarker;
  logic [2*CW-1:0]   nominalPeriod;
  logic [1:0]        clearErrors;
  logic [1:0]        isValid, markerStrobe;
  logic [2*CW-1:0]   period;
  logic [2*EW-1:0]   errorCount;

  logic [CW-1:0]     nominal2;
  logic              clear2, isValid2, strobe2;
  logic [CW-1:0]     period2;
  logic [3:0]        err2;

  assign evrMarker = {m1, m0};

  always #5 sysClk = ~sysClk;

  evr_marker_monitor #(
    .CHANNELS(2), .COUNT_WIDTH(CW), .TOL_SHIFT(3), .GOOD_REQUIRED(2),
    .ERR_WIDTH(EW), .DEBUG("false")
  ) dut (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .evrMarker(evrMarker),
    .nominalPeriod(nominalPeriod), .clearErrors(clearErrors),
    .isValid(isValid), .markerStrobe(markerStrobe),
    .period(period), .errorCount(errorCount)
  );

  // Narrow error counter so saturation is reachable in a short run.
  evr_marker_monitor #(
    .CHANNELS(1), .COUNT_WIDTH(CW), .TOL_SHIFT(3), .GOOD_REQUIRED(2),
    .ERR_WIDTH(4), .DEBUG("false")
  ) dutSat (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .evrMarker(m2),
    .nominalPeriod(nominal2), .clearErrors(clear2),
    .isValid(isValid2), .markerStrobe(strobe2),
    .period(period2), .errorCount(err2)
  );

  typedef struct {
    int          cyc;
    logic [63:0] per;
    logic [63:0] val;
    logic [63:0] err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;
  int   lastRise0 = 0;

  always @(posedge sysClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Rise at the current negedge; strobe expected on the 4th following posedge.
  task automatic pulse(input int ch, input int gapAfter, input int per,
                       input int val, input int err);
    exp_t e;
    e.cyc = cyc + 4;
    e.per = 64'(per);
    e.val = 64'(val);
    e.err = 64'(err);
    if (ch == 0) begin
      q0.push_back(e);
      lastRise0 = cyc;
      m0 = 1'b1;
    end else begin
      q1.push_back(e);
      m1 = 1'b1;
    end
    repeat (3) @(negedge sysClk);
    if (ch == 0) m0 = 1'b0;
    else         m1 = 1'b0;
    repeat (gapAfter - 3) @(negedge sysClk);
  endtask

  always @(negedge sysClk) begin : mon0
    exp_t e;
    if (sysRst_n && markerStrobe[0]) begin
      if (q0.size() == 0) check("ch0 unexpected strobe", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        check("ch0 strobe cycle", 64'(cyc), 64'(e.cyc));
        check("ch0 period", 64'(period[CW-1:0]), e.per);
        check("ch0 isValid", 64'(isValid[0]), e.val);
        check("ch0 errorCount", 64'(errorCount[EW-1:0]), e.err);
      end
    end
  end

  always @(negedge sysClk) begin : mon1
    exp_t e;
    if (sysRst_n && markerStrobe[1]) begin
      if (q1.size() == 0) check("ch1 unexpected strobe", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        check("ch1 strobe cycle", 64'(cyc), 64'(e.cyc));
        check("ch1 period", 64'(period[2*CW-1:CW]), e.per);
        check("ch1 isValid", 64'(isValid[1]), e.val);
        check("ch1 errorCount", 64'(errorCount[2*EW-1:EW]), e.err);
      end
    end
  end

  // gapAfter, expected period, isValid, errorCount (spacing = previous gapAfter)
  int rows [12][4] = '{
    '{100,   0, 0, 0}, '{100, 100, 0, 0}, '{ 80, 100, 1, 0},
    '{100,  80, 0, 1}, '{100, 100, 0, 1}, '{ 88, 100, 1, 1},
    '{112,  88, 1, 1}, '{ 87, 112, 1, 1}, '{113,  87, 0, 2},
    '{100, 113, 0, 3}, '{100, 100, 0, 3}, '{  3, 100, 1, 3}
  };

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s;
    sysRst_n      = 1'b0;
    nominalPeriod = {28'd0, 28'd100};
    clearErrors   = 2'b00;
    nominal2      = 28'd100;
    clear2        = 1'b0;
    repeat (3) @(negedge sysClk);
    check("reset isValid", 64'(isValid), 64'd0);
    check("reset markerStrobe", 64'(markerStrobe), 64'd0);
    check("reset period", 64'(period), 64'd0);
    check("reset errorCount", 64'(errorCount), 64'd0);
    sysRst_n = 1'b1;
    repeat (2) @(negedge sysClk);

    fork
      begin
        for (int i = 0; i < 12; i++)
          pulse(0, rows[i][0], rows[i][1], rows[i][2], rows[i][3]);
        s = lastRise0 + 4;
        while (cyc < s + 112) @(negedge sysClk);
        check("ch0 valid before timeout", 64'(isValid[0]), 64'd1);
        check("ch0 err before timeout", 64'(errorCount[EW-1:0]), 64'd3);
        @(negedge sysClk);
        check("ch0 valid at timeout", 64'(isValid[0]), 64'd0);
        check("ch0 err at timeout", 64'(errorCount[EW-1:0]), 64'd4);
        repeat (300) @(negedge sysClk);
        check("ch0 timeout counted once", 64'(errorCount[EW-1:0]), 64'd4);
        check("ch0 period kept on timeout", 64'(period[CW-1:0]), 64'd100);
      end
      begin
        for (int j = 0; j < 20; j++)
          pulse(1, int'($urandom_range(6, 150)), 0, 0, 0);
      end
    join
    check("ch1 disabled isValid", 64'(isValid[1]), 64'd0);
    check("ch1 disabled errorCount", 64'(errorCount[2*EW-1:EW]), 64'd0);

    fork
      begin
        pulse(0, 100, 100, 0, 4);
        pulse(0, 100, 100, 0, 4);
        pulse(0, 10, 100, 1, 4);
      end
      begin
        nominalPeriod[2*CW-1:CW] = 28'd100;
        pulse(1, 100, 0, 0, 0);
        pulse(1, 100, 100, 0, 0);
        pulse(1, 10, 100, 1, 0);
      end
    join

    clearErrors = 2'b01;
    @(negedge sysClk);
    clearErrors = 2'b00;
    check("ch0 clearErrors", 64'(errorCount[EW-1:0]), 64'd0);
    check("ch0 valid after clear", 64'(isValid[0]), 64'd1);

    check("pre-reset isValid", 64'(isValid), 64'd3);
    @(negedge sysClk);
    #2 sysRst_n = 1'b0;
    #1;
    check("async reset isValid", 64'(isValid), 64'd0);
    check("async reset period", 64'(period), 64'd0);
    check("async reset errorCount", 64'(errorCount), 64'd0);
    check("async reset strobe", 64'(markerStrobe), 64'd0);
    @(negedge sysClk);
    sysRst_n = 1'b1;
    repeat (2) @(negedge sysClk);

    for (int k = 0; k < 20; k++) begin
      m2 = 1'b1;
      repeat (3) @(negedge sysClk);
      m2 = 1'b0;
      repeat (7) @(negedge sysClk);
      if (k == 4) check("sat err after 4 early", 64'(err2), 64'd4);
    end
    check("sat err holds all-ones", 64'(err2), 64'd15);
    check("sat period", 64'(period2), 64'd10);
    check("sat isValid", 64'(isValid2), 64'd0);
    clear2 = 1'b1;
    @(negedge sysClk);
    clear2 = 1'b0;
    check("sat clearErrors", 64'(err2), 64'd0);

    // Clear asserted on the same edge as an early-edge increment.
    m2 = 1'b1;
    repeat (3) @(negedge sysClk);
    m2 = 1'b0;
    clear2 = 1'b1;
    @(negedge sysClk);
    clear2 = 1'b0;
    check("clear beats increment", 64'(err2), 64'd0);
    repeat (6) @(negedge sysClk);
    m2 = 1'b1;
    repeat (3) @(negedge sysClk);
    m2 = 1'b0;
    repeat (3) @(negedge sysClk);
    check("increment after clear", 64'(err2), 64'd1);

    check("ch0 scoreboard drained", 64'(q0.size()), 64'd0);
    check("ch1 scoreboard drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
